// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station: allocate, snoop ALU/LSB broadcasts, issue lowest ready entry
module rs_alu #(
   parameter int RS_SIZE   = 16,
   parameter int ROB_POS_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue_en,
   input  logic [6:0]           issue_opcode,
   input  logic [2:0]           issue_funct3,
   input  logic                 issue_funct7,
   input  logic [31:0]          issue_val1,
   input  logic [31:0]          issue_val2,
   input  logic                 issue_rdy1,
   input  logic                 issue_rdy2,
   input  logic [ROB_POS_W-1:0] issue_tag1,
   input  logic [ROB_POS_W-1:0] issue_tag2,
   input  logic [31:0]          issue_imm,
   input  logic [31:0]          issue_pc,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   output logic                 full,
   input  logic                 alu_result,
   input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
   input  logic [31:0]          alu_result_val,
   input  logic                 lsb_result,
   input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
   input  logic [31:0]          lsb_result_val,
   output logic                 alu_en,
   output logic [6:0]           opcode,
   output logic [2:0]           funct3,
   output logic                 funct7,
   output logic [31:0]          val1,
   output logic [31:0]          val2,
   output logic [31:0]          imm,
   output logic [31:0]          pc,
   output logic [ROB_POS_W-1:0] rob_pos
);
   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0]   busy_q, busy_d;
   logic [RS_SIZE-1:0]   e_rdy1_q, e_rdy2_q;
   logic [6:0]           e_opcode_q [RS_SIZE];
   logic [2:0]           e_funct3_q [RS_SIZE];
   logic [RS_SIZE-1:0]   e_funct7_q;
   logic [31:0]          e_val1_q   [RS_SIZE];
   logic [31:0]          e_val2_q   [RS_SIZE];
   logic [ROB_POS_W-1:0] e_tag1_q   [RS_SIZE];
   logic [ROB_POS_W-1:0] e_tag2_q   [RS_SIZE];
   logic [31:0]          e_imm_q    [RS_SIZE];
   logic [31:0]          e_pc_q     [RS_SIZE];
   logic [ROB_POS_W-1:0] e_rob_q    [RS_SIZE];

   logic [IDX_W-1:0] free_idx, sel_idx;
   logic             sel_vld, alloc;

   // Returns {ready, value}; the ALU bus takes priority when both buses carry the tag.
   function automatic logic [32:0] wake(input logic r, input logic [ROB_POS_W-1:0] t,
                                        input logic [31:0] v);
      logic [32:0] res;
      res = {r, v};
      if (!r) begin
         if (alu_result && alu_result_rob_pos == t)      res = {1'b1, alu_result_val};
         else if (lsb_result && lsb_result_rob_pos == t) res = {1'b1, lsb_result_val};
      end
      return res;
   endfunction

   assign full  = &busy_q;
   assign alloc = issue_en && !full && !rollback;

   always_comb begin
      free_idx = '0;
      sel_idx  = '0;
      sel_vld  = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) free_idx = i[IDX_W-1:0];
         if (busy_q[i] && e_rdy1_q[i] && e_rdy2_q[i]) begin
            sel_idx = i[IDX_W-1:0];
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (rollback) begin
         busy_d = '0;
      end else begin
         if (sel_vld) busy_d[sel_idx] = 1'b0;
         if (alloc)   busy_d[free_idx] = 1'b1;
      end
   end

   // Entry payload carries no reset; busy_q alone decides validity.
   always_ff @(posedge clk) begin
      if (rdy && !rollback) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               {e_rdy1_q[i], e_val1_q[i]} <= wake(e_rdy1_q[i], e_tag1_q[i], e_val1_q[i]);
               {e_rdy2_q[i], e_val2_q[i]} <= wake(e_rdy2_q[i], e_tag2_q[i], e_val2_q[i]);
            end
         end
         if (alloc) begin
            e_opcode_q[free_idx] <= issue_opcode;
            e_funct3_q[free_idx] <= issue_funct3;
            e_funct7_q[free_idx] <= issue_funct7;
            e_tag1_q[free_idx]   <= issue_tag1;
            e_tag2_q[free_idx]   <= issue_tag2;
            e_imm_q[free_idx]    <= issue_imm;
            e_pc_q[free_idx]     <= issue_pc;
            e_rob_q[free_idx]    <= issue_rob_pos;
            {e_rdy1_q[free_idx], e_val1_q[free_idx]} <= wake(issue_rdy1, issue_tag1, issue_val1);
            {e_rdy2_q[free_idx], e_val2_q[free_idx]} <= wake(issue_rdy2, issue_tag2, issue_val2);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         alu_en  <= 1'b0;
         opcode  <= '0;
         funct3  <= '0;
         funct7  <= 1'b0;
         val1    <= '0;
         val2    <= '0;
         imm     <= '0;
         pc      <= '0;
         rob_pos <= '0;
      end else if (rdy) begin
         busy_q <= busy_d;
         if (rollback) begin
            alu_en <= 1'b0;
         end else begin
            alu_en <= sel_vld;
            if (sel_vld) begin
               opcode  <= e_opcode_q[sel_idx];
               funct3  <= e_funct3_q[sel_idx];
               funct7  <= e_funct7_q[sel_idx];
               val1    <= e_val1_q[sel_idx];
               val2    <= e_val2_q[sel_idx];
               imm     <= e_imm_q[sel_idx];
               pc      <= e_pc_q[sel_idx];
               rob_pos <= e_rob_q[sel_idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - directed table, corner sequences and randomized model check for rs_alu
module tb_rs_alu;
   logic        clk = 1'b0;
   logic        rst_n, rdy, rollback, issue_en;
   logic [6:0]  issue_opcode;
   logic [2:0]  issue_funct3;
   logic        issue_funct7;
   logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
   logic        issue_rdy1, issue_rdy2;
   logic [3:0]  issue_tag1, issue_tag2, issue_rob_pos;
   logic        full;
   logic        alu_result, lsb_result;
   logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
   logic [31:0] alu_result_val, lsb_result_val;
   logic        alu_en;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] val1, val2, imm, pc;
   logic [3:0]  rob_pos;

   rs_alu #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .issue_en(issue_en),
      .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
      .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_rdy1(issue_rdy1),
      .issue_rdy2(issue_rdy2), .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos), .full(full),
      .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
      .alu_result_val(alu_result_val), .lsb_result(lsb_result),
      .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
      .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7), .val1(val1),
      .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1'b1; rollback = 1'b0; issue_en = 1'b0;
      alu_result = 1'b0; lsb_result = 1'b0;
   endtask

   task automatic set_issue(input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                            input logic [31:0] v2, input logic r2, input logic [3:0] t2,
                            input logic [3:0] rob);
      issue_en = 1'b1; issue_opcode = 7'b0110011; issue_funct3 = 3'b000; issue_funct7 = 1'b0;
      issue_val1 = v1; issue_rdy1 = r1; issue_tag1 = t1;
      issue_val2 = v2; issue_rdy2 = r2; issue_tag2 = t2;
      issue_imm = 32'h1000 + {28'd0, rob}; issue_pc = 32'h8000 + {28'd0, rob}; issue_rob_pos = rob;
   endtask

   task automatic bc_alu(input logic [3:0] t, input logic [31:0] v);
      alu_result = 1'b1; alu_result_rob_pos = t; alu_result_val = v;
   endtask

   task automatic bc_lsb(input logic [3:0] t, input logic [31:0] v);
      lsb_result = 1'b1; lsb_result_rob_pos = t; lsb_result_val = v;
   endtask

   typedef struct {
      logic r1, r2; logic [3:0] t1, t2; logic [31:0] v1, v2;
      logic ba, bl; logic [3:0] bta, btl; logic [31:0] bva, bvl;
      logic en; logic [31:0] ev1, ev2;
   } vec_t;

   // Behavioural model: a slot table with busy flags, stepped once per clock edge.
   typedef struct {
      bit busy, r1, r2, f7; bit [6:0] op; bit [2:0] f3; bit [3:0] t1, t2, rob;
      bit [31:0] v1, v2, imm, pc;
   } ent_t;
   ent_t m[16];
   bit        m_en, m_f7;
   bit [6:0]  m_op;
   bit [2:0]  m_f3;
   bit [31:0] m_v1, m_v2, m_imm, m_pc;
   bit [3:0]  m_rob;

   function automatic bit [32:0] m_wake(input bit r, input bit [3:0] t, input bit [31:0] v);
      if (r) return {1'b1, v};
      if (alu_result && t == alu_result_rob_pos) return {1'b1, alu_result_val};
      if (lsb_result && t == lsb_result_rob_pos) return {1'b1, lsb_result_val};
      return {1'b0, v};
   endfunction

   function automatic int m_busy_cnt();
      int c = 0;
      foreach (m[i]) if (m[i].busy) c++;
      return c;
   endfunction

   task automatic model_step();
      int sel = -1;
      int fr = -1;
      bit [32:0] w;
      if (!rdy) return;
      if (rollback) begin
         foreach (m[i]) m[i].busy = 1'b0;
         m_en = 1'b0;
         return;
      end
      for (int i = 15; i >= 0; i--) begin
         if (m[i].busy && m[i].r1 && m[i].r2) sel = i;
         if (!m[i].busy) fr = i;
      end
      foreach (m[i]) if (m[i].busy) begin
         w = m_wake(m[i].r1, m[i].t1, m[i].v1); m[i].r1 = w[32]; m[i].v1 = w[31:0];
         w = m_wake(m[i].r2, m[i].t2, m[i].v2); m[i].r2 = w[32]; m[i].v2 = w[31:0];
      end
      m_en = (sel >= 0);
      if (sel >= 0) begin
         m_op = m[sel].op; m_f3 = m[sel].f3; m_f7 = m[sel].f7; m_v1 = m[sel].v1;
         m_v2 = m[sel].v2; m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
         m[sel].busy = 1'b0;
      end
      if (issue_en && fr >= 0) begin
         m[fr].busy = 1'b1; m[fr].op = issue_opcode; m[fr].f3 = issue_funct3;
         m[fr].f7 = issue_funct7; m[fr].t1 = issue_tag1; m[fr].t2 = issue_tag2;
         m[fr].imm = issue_imm; m[fr].pc = issue_pc; m[fr].rob = issue_rob_pos;
         w = m_wake(issue_rdy1, issue_tag1, issue_val1); m[fr].r1 = w[32]; m[fr].v1 = w[31:0];
         w = m_wake(issue_rdy2, issue_tag2, issue_val2); m[fr].r2 = w[32]; m[fr].v2 = w[31:0];
      end
   endtask

   vec_t vt[9];

   initial begin
      vt[0] = '{1, 1, 0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 1, 5, 7};
      vt[1] = '{1, 0, 0, 9, 1, 32'hDEAD, 1, 0, 9, 0, 32'hABCD, 0, 1, 1, 32'hABCD};
      vt[2] = '{0, 1, 3, 0, 32'hDEAD, 2, 0, 1, 0, 3, 0, 32'h1234, 1, 32'h1234, 2};
      vt[3] = '{0, 1, 7, 0, 32'hDEAD, 3, 1, 1, 7, 7, 32'hAAAA, 32'hBBBB, 1, 32'hAAAA, 3};
      vt[4] = '{0, 1, 2, 0, 32'hDEAD, 4, 1, 0, 5, 0, 32'h5555, 0, 0, 0, 0};
      vt[5] = '{0, 0, 1, 8, 32'hDEAD, 32'hBEEF, 1, 1, 1, 8, 32'h11, 32'h88, 1, 32'h11, 32'h88};
      vt[6] = '{0, 1, 4, 0, 32'hDEAD, 6, 1, 0, 4, 0, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 6};
      vt[7] = '{1, 0, 0, 0, 8, 32'hDEAD, 0, 1, 0, 0, 0, 32'h0, 1, 8, 0};
      vt[8] = '{1, 1, 6, 6, 32'h55, 32'h66, 1, 0, 6, 0, 32'h99, 0, 1, 32'h55, 32'h66};

      idle();
      set_issue(0, 0, 0, 0, 0, 0, 0);
      issue_en = 1'b0;
      alu_result_rob_pos = 0; alu_result_val = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;
      rst_n = 1'b0;
      step(); step();
      chk("reset alu_en", alu_en, 0);
      chk("reset full", full, 0);
      chk("reset val1", val1, 0);
      chk("reset rob_pos", rob_pos, 0);
      chk("reset opcode", opcode, 0);
      rst_n = 1'b1;
      step();

      // basic add, minimum latency
      set_issue(5, 1, 0, 7, 1, 0, 3); step();
      idle(); chk("add en early", alu_en, 0); step();
      chk("add en", alu_en, 1); chk("add val1", val1, 5); chk("add val2", val2, 7);
      chk("add rob", rob_pos, 3); chk("add opcode", opcode, 7'b0110011);
      step(); chk("add en drop", alu_en, 0);

      // late wakeup from LSB bus
      set_issue(0, 0, 6, 2, 1, 0, 5); step();
      idle(); step(); chk("lsbw wait1", alu_en, 0);
      step(); chk("lsbw wait2", alu_en, 0);
      bc_lsb(6, 32'h100); step(); chk("lsbw at W", alu_en, 0);
      idle(); step();
      chk("lsbw en", alu_en, 1); chk("lsbw val1", val1, 32'h100); chk("lsbw rob", rob_pos, 5);
      step(); chk("lsbw drop", alu_en, 0);

      // table: same-cycle wakeup variants
      for (int k = 0; k < 9; k++) begin
         set_issue(vt[k].v1, vt[k].r1, vt[k].t1, vt[k].v2, vt[k].r2, vt[k].t2, 4'(k + 4));
         if (vt[k].ba) bc_alu(vt[k].bta, vt[k].bva);
         if (vt[k].bl) bc_lsb(vt[k].btl, vt[k].bvl);
         step();
         idle(); step();
         chk($sformatf("vec%0d en", k), alu_en, vt[k].en);
         if (vt[k].en) begin
            chk($sformatf("vec%0d val1", k), val1, vt[k].ev1);
            chk($sformatf("vec%0d val2", k), val2, vt[k].ev2);
            chk($sformatf("vec%0d rob", k), rob_pos, k + 4);
         end
         rollback = 1'b1; step(); idle();
      end

      // fill all entries
      for (int i = 0; i < 16; i++) begin
         set_issue(0, 0, 4'(i), i, 1, 0, 4'(i)); step();
         if (i == 14) chk("fill 15 not full", full, 0);
      end
      idle(); chk("fill full", full, 1);
      bc_alu(4, 32'h4444); step(); idle();
      chk("fill W full", full, 1); chk("fill W en", alu_en, 0);
      step();
      chk("e4 en", alu_en, 1); chk("e4 rob", rob_pos, 4); chk("e4 val1", val1, 32'h4444);
      chk("e4 freed full", full, 0);
      set_issue(0, 0, 2, 32'h44, 1, 0, 4); step(); idle();
      chk("refill full", full, 1); chk("refill en", alu_en, 0);
      bc_lsb(2, 32'h22); step(); idle(); step();
      chk("pair first en", alu_en, 1); chk("pair first rob", rob_pos, 2);
      chk("pair first val2", val2, 2);
      step();
      chk("pair second en", alu_en, 1); chk("pair second val2", val2, 32'h44);
      chk("pair second val1", val1, 32'h22);
      step(); chk("pair done", alu_en, 0);

      // rollback with pending ready entry
      rollback = 1'b1; step(); idle();
      for (int i = 1; i <= 4; i++) begin set_issue(0, 0, 4'(i), 0, 1, 0, 4'(i)); step(); end
      set_issue(1, 1, 0, 1, 1, 0, 7); step(); idle();
      rollback = 1'b1; step(); idle();
      chk("rb en", alu_en, 0); chk("rb full", full, 0);
      bc_alu(1, 32'h77); step(); idle(); chk("rb bc en1", alu_en, 0);
      step(); chk("rb bc en2", alu_en, 0);

      // rdy low freezes everything
      set_issue(32'h111, 1, 0, 0, 1, 0, 9); step();
      set_issue(32'h222, 1, 0, 0, 1, 0, 10); step();
      chk("frz pre en", alu_en, 1); chk("frz pre rob", rob_pos, 9);
      set_issue(32'h333, 1, 0, 0, 1, 0, 11); rdy = 1'b0; rollback = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("frz%0d en", i), alu_en, 1); chk($sformatf("frz%0d rob", i), rob_pos, 9);
         chk($sformatf("frz%0d val1", i), val1, 32'h111);
      end
      idle(); step();
      chk("thaw en", alu_en, 1); chk("thaw rob", rob_pos, 10); chk("thaw val1", val1, 32'h222);
      step(); chk("thaw no z", alu_en, 0);

      // async reset between edges
      set_issue(32'h333, 1, 0, 32'h3, 1, 0, 14); step();
      set_issue(0, 0, 5, 0, 1, 0, 13); step(); idle();
      chk("ar pre en", alu_en, 1);
      #3; rst_n = 1'b0; #1;
      chk("ar en", alu_en, 0); chk("ar val1", val1, 0); chk("ar rob", rob_pos, 0);
      chk("ar imm", imm, 0); chk("ar pc", pc, 0);
      step(); rst_n = 1'b1; step();

      // randomized against the model
      foreach (m[i]) m[i].busy = 1'b0;
      m_en = 0; m_op = 0; m_f3 = 0; m_f7 = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
      for (int c = 0; c < 1500; c++) begin
         rdy = ($urandom_range(9) != 0);
         rollback = ($urandom_range(40) == 0);
         issue_en = ($urandom_range(9) < 6);
         issue_opcode = 7'($urandom); issue_funct3 = 3'($urandom); issue_funct7 = 1'($urandom);
         issue_val1 = $urandom; issue_val2 = $urandom; issue_imm = $urandom; issue_pc = $urandom;
         issue_rdy1 = ($urandom_range(2) == 0); issue_rdy2 = ($urandom_range(2) == 0);
         issue_tag1 = 4'($urandom); issue_tag2 = 4'($urandom); issue_rob_pos = 4'($urandom);
         alu_result = ($urandom_range(2) == 0); alu_result_rob_pos = 4'($urandom);
         alu_result_val = $urandom;
         lsb_result = ($urandom_range(2) == 0); lsb_result_rob_pos = 4'($urandom);
         lsb_result_val = $urandom;
         model_step();
         step();
         chk("rnd en", alu_en, m_en);
         chk("rnd full", full, m_busy_cnt() == 16);
         chk("rnd opcode", opcode, m_op); chk("rnd f3", funct3, m_f3); chk("rnd f7", funct7, m_f7);
         chk("rnd val1", val1, m_v1); chk("rnd val2", val2, m_v2);
         chk("rnd imm", imm, m_imm); chk("rnd pc", pc, m_pc); chk("rnd rob", rob_pos, m_rob);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
